// File: rtl/instr_encoder.sv
// Packs an immediate into a template instruction word for the selected ImmSrc format.
// Packed words stream out through one registered handshake stage, each tagged with a sequential byte address.
module instr_encoder #(
  parameter int                         address_width = 32,
  parameter logic [address_width-1:0]   BASE_ADDR     = '0,
  parameter int                         DEPTH_WORDS   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [address_width-1:0] base_instr,
  input  logic [address_width-1:0] imm,
  input  logic [2:0]               ImmSrc,
  input  logic                     addr_load,
  input  logic [address_width-1:0] addr_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [address_width-1:0] out_instr,
  output logic [address_width-1:0] out_addr,
  output logic                     out_err,
  output logic                     err_sticky,
  output logic [15:0]              word_count
);

  localparam int W = address_width;
  localparam logic [W-1:0] LAST_ADDR = BASE_ADDR + W'(4 * (DEPTH_WORDS - 1));

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;

  // Field positions are the RV32 layout; the word is assumed to be 32 bits wide.
  function automatic logic [W-1:0] pack_imm(input logic [W-1:0] base,
                                            input logic [W-1:0] im,
                                            input logic [2:0]   fmt);
    logic [W-1:0] r;
    case (fmt)
      FMT_I:   r = {im[11:0], base[19:0]};
      FMT_S:   r = {im[11:5], base[24:12], im[4:0], base[6:0]};
      FMT_B:   r = {im[12], im[10:5], base[24:12], im[4:1], im[11], base[6:0]};
      FMT_U:   r = {im[31:12], base[11:0]};
      FMT_J:   r = {im[20], im[10:1], im[11], im[19:12], base[11:0]};
      default: r = base;
    endcase
    return r;
  endfunction

  function automatic logic imm_err(input logic [W-1:0] im,
                                   input logic [2:0]   fmt);
    logic signed [W-1:0] s;
    logic                e;
    s = im;
    case (fmt)
      FMT_I, FMT_S: e = (s < -2048) || (s > 2047);
      FMT_B:        e = (s < -4096) || (s > 4094) || im[0];
      FMT_J:        e = (s < -1048576) || (s > 1048574) || im[0];
      FMT_U:        e = |im[11:0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_instr_q, out_instr_d;
  logic [W-1:0]   out_addr_q,  out_addr_d;
  logic           out_err_q,   out_err_d;
  logic           err_sticky_q, err_sticky_d;
  logic [15:0]    word_count_q, word_count_d;
  logic [W-1:0]   addr_q, addr_d;
  logic           accept;
  logic           enc_err;

  assign in_ready = !addr_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign enc_err  = imm_err(imm, ImmSrc);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_instr_d  = pack_imm(base_instr, imm, ImmSrc);
      out_addr_d   = addr_q;
      out_err_d    = enc_err;
      err_sticky_d = err_sticky_q | enc_err;
      word_count_d = sat_inc(word_count_q);
      addr_d       = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + W'(4);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // addr_load never coincides with accept because it drops in_ready.
    if (addr_load) begin
      addr_d = {addr_in[W-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      word_count_q <= '0;
      addr_q       <= BASE_ADDR;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenario tasks plus a randomized stream scored against a mask/shift model.
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, addr_load, out_valid, out_ready, out_err, err_sticky;
  logic [31:0] base_instr, imm, addr_in, out_instr, out_addr;
  logic [2:0]  ImmSrc;
  logic [15:0] word_count;

  int checks = 0;
  int failures = 0;

  instr_encoder #(.address_width(32), .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .base_instr(base_instr), .imm(imm), .ImmSrc(ImmSrc),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } beat_t;

  // Reference encoding written as masks and shifts over the immediate value.
  function automatic void model_encode(input logic [31:0] base, input logic [31:0] im,
                                       input logic [2:0] src, output logic [31:0] ins,
                                       output logic err);
    int v;
    v = $signed(im);
    case (src)
      3'd0: begin
        ins = (base & 32'h000F_FFFF) | (im << 20);
        err = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        ins = (base & 32'h01FF_F07F) | (((im >> 5) & 32'h7F) << 25) | ((im & 32'h1F) << 7);
        err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        ins = (base & 32'h01FF_F07F) | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
            | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
        err = (v < -4096) || (v > 4094) || ((im & 32'h1) != 0);
      end
      3'd3: begin
        ins = (base & 32'h0000_0FFF) | (im & 32'hFFFF_F000);
        err = (im & 32'hFFF) != 0;
      end
      3'd4: begin
        ins = (base & 32'h0000_0FFF) | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
            | (((im >> 11) & 32'h1) << 20) | (im & 32'h000F_F000);
        err = (v < -1048576) || (v > 1048574) || ((im & 32'h1) != 0);
      end
      default: begin
        ins = base;
        err = 1'b1;
      end
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; addr_load = 0; out_ready = 1; base_instr = 0; imm = 0; ImmSrc = 0; addr_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] b, input logic [31:0] i, input logic [2:0] s);
    in_valid = 1; base_instr = b; imm = i; ImmSrc = s;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    drive(32'h0000_0013, 32'h5, 3'd0);
    rst = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    checks++; if (out_addr !== 32'h0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
    checks++; if (word_count !== 16'h0) begin failures++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    rst = 0;
    idle_inputs();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_i_type();
    do_reset();
    drive(32'h0000_0013, 32'hFFFF_FFFF, 3'd0);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL itype_valid got=%b exp=1", out_valid); end
    checks++; if (out_instr !== 32'hFFF0_0013) begin failures++; $display("FAIL itype_instr got=%h exp=fff00013", out_instr); end
    checks++; if (out_addr !== BASE) begin failures++; $display("FAIL itype_addr got=%h exp=%h", out_addr, BASE); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL itype_err got=%b exp=0", out_err); end
    checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL itype_count got=%0d exp=1", word_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL itype_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b [3] = '{32'h0000_2023, 32'h0000_0063, 32'h0000_006F};
    logic [31:0] v [3] = '{32'd4, 32'd8, 32'hFFFF_FFFC};
    logic [2:0]  s [3] = '{3'd1, 3'd2, 3'd4};
    logic [31:0] e [3] = '{32'h0000_2223, 32'h0000_0463, 32'hFFDF_F06F};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(b[i], v[i], s[i]);
      tick();
      checks++; if (out_instr !== e[i]) begin failures++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, out_instr, e[i]); end
      checks++; if (out_addr !== BASE + 32'(4 * i)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, out_addr, BASE + 32'(4 * i)); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL b2b_err[%0d] got=%b exp=0", i, out_err); end
    end
    in_valid = 0;
    checks++; if (word_count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", word_count); end
  endtask

  task automatic test_errors();
    logic [31:0] rv [10] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'd4094, 32'hFFFF_F000,
                             32'd4096, 32'd1048574, 32'hFFF0_0000, 32'd1048576, 32'd3};
    logic [2:0]  rs [10] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4};
    logic        re [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] mi;
    logic        me;
    do_reset();
    drive(32'h0000_0063, 32'd4097, 3'd2);
    tick();
    checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL err_b4097 got=%b exp=1", out_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_sticky_set got=%b exp=1", err_sticky); end
    drive(32'h0000_0013, 32'd5, 3'd0);
    tick();
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL err_legal got=%b exp=0", out_err); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL err_sticky_hold got=%b exp=1", err_sticky); end
    drive(32'h0000_0037, 32'h1234_5001, 3'd3);
    tick();
    checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL err_u got=%b exp=1", out_err); end
    checks++; if (out_instr !== 32'h1234_5037) begin failures++; $display("FAIL err_u_instr got=%h exp=12345037", out_instr); end
    drive(32'hDEAD_BEEF, 32'h0000_0004, 3'd7);
    tick();
    checks++; if (out_instr !== 32'hDEAD_BEEF) begin failures++; $display("FAIL err_illegal_instr got=%h exp=deadbeef", out_instr); end
    checks++; if (out_err !== 1'b1) begin failures++; $display("FAIL err_illegal got=%b exp=1", out_err); end
    for (int i = 0; i < 10; i++) begin
      drive(32'h1357_9BDF, rv[i], rs[i]);
      tick();
      model_encode(32'h1357_9BDF, rv[i], rs[i], mi, me);
      checks++; if (out_err !== re[i]) begin failures++; $display("FAIL range_err[%0d] got=%b exp=%b", i, out_err, re[i]); end
      checks++; if (out_instr !== mi) begin failures++; $display("FAIL range_instr[%0d] got=%h exp=%h", i, out_instr, mi); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(32'h0000_0013, 32'd1, 3'd0);
    tick();
    out_ready = 0;
    drive(32'h0000_0013, 32'd2, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      checks++; if (out_instr !== 32'h0010_0013) begin failures++; $display("FAIL bp_hold_instr[%0d] got=%h exp=00100013", i, out_instr); end
      checks++; if (out_addr !== BASE) begin failures++; $display("FAIL bp_hold_addr[%0d] got=%h exp=%h", i, out_addr, BASE); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_instr !== 32'h0020_0013) begin failures++; $display("FAIL bp_next_instr got=%h exp=00200013", out_instr); end
    checks++; if (out_addr !== BASE + 32'd4) begin failures++; $display("FAIL bp_next_addr got=%h exp=%h", out_addr, BASE + 32'd4); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++; if (word_count !== 16'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", word_count); end
  endtask

  task automatic test_wrap_load();
    logic [31:0] ea [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(32'h0000_0013, 32'(i), 3'd0);
      tick();
      checks++; if (out_addr !== BASE + ea[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, out_addr, BASE + ea[i]); end
    end
    drive(32'h0000_0013, 32'd9, 3'd0);
    addr_load = 1;
    addr_in = 32'h0000_0103;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL load_in_ready got=%b exp=0", in_ready); end
    tick();
    addr_load = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL load_no_accept got=%b exp=0", out_valid); end
    checks++; if (word_count !== 16'd5) begin failures++; $display("FAIL load_count got=%0d exp=5", word_count); end
    tick();
    in_valid = 0;
    checks++; if (out_addr !== 32'h0000_0100) begin failures++; $display("FAIL load_addr got=%h exp=00000100", out_addr); end
    checks++; if (out_instr !== 32'h0090_0013) begin failures++; $display("FAIL load_instr got=%h exp=00900013", out_instr); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(32'h0000_00AA, 32'd0, 3'd7);
    tick();
    drive(32'h0000_0013, 32'd0, 3'd0);
    tick();
    in_valid = 0;
    out_ready = 0;
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_stall_valid got=%b exp=1", out_valid); end
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL mid_sticky_pre got=%b exp=1", err_sticky); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", word_count); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL mid_sticky got=%b exp=0", err_sticky); end
    out_ready = 1;
    drive(32'h0000_0013, 32'd1, 3'd0);
    tick();
    in_valid = 0;
    checks++; if (out_addr !== BASE) begin failures++; $display("FAIL mid_addr got=%h exp=%h", out_addr, BASE); end
    tick();
  endtask

  task automatic test_random();
    beat_t       q[$];
    beat_t       nb;
    logic [31:0] ea;
    logic [15:0] ecount;
    logic        esticky, erdy;
    do_reset();
    ea = BASE; ecount = 0; esticky = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 7);
      addr_load  = ($urandom_range(0, 19) == 0);
      addr_in    = $urandom_range(0, 31);
      base_instr = $urandom();
      ImmSrc     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: imm = $urandom();
        2: imm = $urandom() & 32'hFFFF_F000;
        default: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      endcase
      #1;
      erdy = !addr_load && (q.size() == 0 || out_ready);
      checks++; if (in_ready !== erdy) begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, erdy); end
      checks++; if (out_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if ({out_instr, out_addr, out_err} !== q[0]) begin failures++; $display("FAIL rnd_beat c=%0d got=%h/%h/%b exp=%h/%h/%b", c, out_instr, out_addr, out_err, q[0].instr, q[0].addr, q[0].err); end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && erdy) begin
        model_encode(base_instr, imm, ImmSrc, nb.instr, nb.err);
        nb.addr = ea;
        q.push_back(nb);
        ea = (ea == BASE + 32'(4 * (DEPTH - 1))) ? BASE : ea + 32'd4;
        if (ecount != 16'hFFFF) ecount = ecount + 16'd1;
        esticky = esticky | nb.err;
      end
      if (addr_load) ea = {addr_in[31:2], 2'b00};
      tick();
      checks++; if (word_count !== ecount) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, word_count, ecount); end
      checks++; if (err_sticky !== esticky) begin failures++; $display("FAIL rnd_sticky c=%0d got=%b exp=%b", c, err_sticky, esticky); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    test_reset();
    test_i_type();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_wrap_load();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the CPU's immediate-extension path. It takes a template instruction word plus a 32-bit immediate and an ImmSrc format code, then packs the immediate into that format's bit positions. It range-checks the immediate and streams the finished word, tagged with a sequential instruction-memory byte address, to a downstream writer (program loader / self-test instruction generator). Input and output use a valid/ready handshake and are separated by one registered pipeline stage with backpressure.

Parameters:
address_width, 32, width of instruction words, immediates and addresses
BASE_ADDR, 32'h0000_0000, byte address given to the first word after reset
DEPTH_WORDS, 256, instruction-memory depth in words; address wraps to BASE_ADDR after DEPTH_WORDS words

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word offered
in_ready  output  1  input word accepted when in_valid && in_ready
base_instr  input  address_width  template: opcode/rd/rs1/rs2/funct bits; its immediate bit positions are ignored
imm  input  address_width  immediate value, two's complement
ImmSrc  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
addr_load  input  1  load address counter from addr_in
addr_in  input  address_width  new byte address (bits [1:0] ignored, forced 0)
out_valid  output  1  encoded word held in output register
out_ready  input  1  downstream accepts when out_valid && out_ready
out_instr  output  address_width  encoded instruction
out_addr  output  address_width  byte address for out_instr
out_err  output  1  immediate not representable or ImmSrc illegal, for this word
err_sticky  output  1  set by any emitted word with out_err; cleared only by rst
word_count  output  16  words accepted since reset, saturating at 16'hFFFF

Behaviour:
- Reset (rst high at a clk edge): out_valid=0, out_instr=0, out_addr=0, out_err=0, err_sticky=0, word_count=0, address counter=BASE_ADDR. Reset mid-transfer drops the held word.
- in_ready = !addr_load && (!out_valid || out_ready), combinational. Full-throughput handshake, one word per cycle.
- On accept: output register loads out_instr/out_addr/out_err next edge, and out_valid=1. Latency is 1 cycle from accept to out_valid. out_addr = current counter. Counter advances by 4. At BASE_ADDR + 4*(DEPTH_WORDS-1) it wraps to BASE_ADDR. word_count increments.
- out_valid && !out_ready: all outputs hold stable and in_ready=0.
- out_valid && out_ready && !in_valid: out_valid clears next edge.
- addr_load: counter = {addr_in[31:2],2'b00} next edge. It blocks acceptance that cycle, so there is no same-cycle conflict. It does not disturb a word already in the output register.
- Packing: non-immediate bits copy from base_instr.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
- Error (out_err=1), word still emitted with truncated packing:
  - I/S: imm outside [-2048,2047].
  - B: outside [-4096,4094] or imm[0]=1.
  - J: outside [-1048576,1048574] or imm[0]=1.
  - U: imm[11:0]!=0.
  - ImmSrc illegal: out_instr=base_instr unchanged.
- err_sticky sets on the edge the erroneous word loads into the output register.

Test Plan:
- I-type: base 32'h00000013, imm 32'hFFFFFFFF, ImmSrc 000, out_ready=1 → next cycle out_instr=32'hFFF00013, out_addr=BASE_ADDR, out_err=0.
- S/B/J packing: sw base 32'h00002023 imm 4 S → 32'h00002223. beq base 32'h00000063 imm 8 B → 32'h00000463. jal base 32'h0000006F imm -4 J → 32'hFFDFF06F. Sent back-to-back, out_addr 0,4,8.
- Errors: B imm 4097 → out_err=1 and err_sticky=1, remaining set after a following legal word. U imm 32'h12345001 → out_err=1. ImmSrc 111 → out_instr=base_instr, out_err=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_instr/out_addr stable, no word lost or duplicated. Release → stream resumes in order.
- Wrap/load: DEPTH_WORDS=4, send 5 words → addresses 0,4,8,12,0. Then addr_load with addr_in=32'h103 alongside in_valid → no accept that cycle, next word at 32'h100.
- Reset mid-operation: rst while out_valid=1 && out_ready=0 → next cycle out_valid=0, counter=BASE_ADDR, word_count=0, err_sticky=0.
